// File: rtl/comparator_bank.sv
// comparator_bank
//   Compares CHANNELS pairs of IEEE-754 single-precision operands per sweep
//   through one shared compare pipeline, then publishes all per-channel
//   greater/less flags together with a one-cycle done pulse.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   sta       start pulse, accepted only in IDLE
//   input_1   operand A, channel k at [k*WIDTH +: WIDTH]
//   input_2   operand B, same packing
//   output_1  bit k = A_k > B_k
//   output_2  bit k = A_k < B_k
//   busy      high whenever the sequencer is not IDLE
//   done_sig  one-cycle pulse; output_1/output_2 are valid from this cycle
//
// Build option
//   COMPARATOR_DEBOUNCE_EN  when defined, a channel's outputs only change after
//                           DEB_COUNT consecutive sweeps agree on a new value.
//
// state | meaning
// IDLE  | waiting for sta
// ISSUE | feeding one captured channel per cycle into the compare pipe
// DRAIN | waiting for the last channel to leave the pipe
// DONE  | outputs just updated, done_sig high for this cycle

module comparator_bank #(
  parameter int WIDTH       = 32,
  parameter int CHANNELS    = 4,
  parameter int CMP_LATENCY = 1,
  parameter int DEB_COUNT   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sta,
  input  logic [CHANNELS*WIDTH-1:0] input_1,
  input  logic [CHANNELS*WIDTH-1:0] input_2,
  output logic [CHANNELS-1:0]       output_1,
  output logic [CHANNELS-1:0]       output_2,
  output logic                      busy,
  output logic                      done_sig
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CHANNELS - 1);
  localparam int LS = CMP_LATENCY - 1;

  generate
    if (WIDTH != 32) begin : g_bad_width
      $error("comparator_bank: WIDTH must be 32");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $error("comparator_bank: CHANNELS must be 1..16");
    end
    if (CMP_LATENCY < 1 || CMP_LATENCY > 3) begin : g_bad_latency
      $error("comparator_bank: CMP_LATENCY must be 1..3");
    end
    if (DEB_COUNT < 2 || DEB_COUNT > 15) begin : g_bad_deb
      $error("comparator_bank: DEB_COUNT must be 2..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     idx;
  logic [WIDTH-1:0]  sh_a [CHANNELS];
  logic [WIDTH-1:0]  sh_b [CHANNELS];
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic              p_vld [CMP_LATENCY];
  logic [IW-1:0]     p_idx [CMP_LATENCY];
  logic [1:0]        p_res [CMP_LATENCY];
  logic [CHANNELS-1:0] res_gt, res_lt;
  logic [CHANNELS-1:0] o1_nxt, o2_nxt;
  logic              accept, issue, pipe_empty, sweep_end;

  // Sign-magnitude ordering; returns {a_gt_b, a_lt_b}.
  function automatic logic [1:0] fcmp(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
    logic a_nan, b_nan, zeros, mag_gt, mag_lt;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    zeros  = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    mag_gt = a[30:0] > b[30:0];
    mag_lt = a[30:0] < b[30:0];
    if (a_nan || b_nan || zeros) return 2'b00;
    else if (a[31] != b[31])     return a[31] ? 2'b01 : 2'b10;
    else if (!a[31])             return {mag_gt, mag_lt};
    else                         return {mag_lt, mag_gt};
  endfunction

  assign accept    = (state == IDLE) && sta;
  assign issue     = (state == ISSUE);
  assign sweep_end = (state == DRAIN) && pipe_empty;
  assign busy      = (state != IDLE);
  assign done_sig  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sta) state_nxt = ISSUE;
      ISSUE:   if (idx == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   if (pipe_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         idx <= '0;
    else if (accept) idx <= '0;
    else if (issue)  idx <= idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        sh_a[k] <= '0;
        sh_b[k] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < CHANNELS; k++) begin
        sh_a[k] <= input_1[k*WIDTH +: WIDTH];
        sh_b[k] <= input_2[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == IW'(k)) begin
        sel_a = sh_a[k];
        sel_b = sh_b[k];
      end
    end
  end

  // Compare is resolved into stage 0; later stages only carry the result,
  // so CMP_LATENCY trades timing slack for latency without changing results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < CMP_LATENCY; s++) begin
        p_vld[s] <= 1'b0;
        p_idx[s] <= '0;
        p_res[s] <= '0;
      end
    end else begin
      p_vld[0] <= issue;
      p_idx[0] <= idx;
      p_res[0] <= fcmp(sel_a, sel_b);
      for (int s = 1; s < CMP_LATENCY; s++) begin
        p_vld[s] <= p_vld[s-1];
        p_idx[s] <= p_idx[s-1];
        p_res[s] <= p_res[s-1];
      end
    end
  end

  always_comb begin
    pipe_empty = 1'b1;
    for (int s = 0; s < CMP_LATENCY; s++) begin
      if (p_vld[s]) pipe_empty = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_gt <= '0;
      res_lt <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (p_vld[LS] && (p_idx[LS] == IW'(k))) begin
          res_gt[k] <= p_res[LS][1];
          res_lt[k] <= p_res[LS][0];
        end
      end
    end
  end

`ifdef COMPARATOR_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_COUNT + 1);

  logic [DW-1:0] deb_cnt      [CHANNELS];
  logic [1:0]    deb_cand     [CHANNELS];
  logic [DW-1:0] deb_cnt_nxt  [CHANNELS];
  logic [1:0]    deb_cand_nxt [CHANNELS];

  always_comb begin
    o1_nxt = output_1;
    o2_nxt = output_2;
    for (int k = 0; k < CHANNELS; k++) begin
      deb_cnt_nxt[k]  = deb_cnt[k];
      deb_cand_nxt[k] = deb_cand[k];
      if ({res_gt[k], res_lt[k]} == {output_1[k], output_2[k]}) begin
        deb_cnt_nxt[k] = '0;
      end else if ({res_gt[k], res_lt[k]} == deb_cand[k]) begin
        // This sweep is the DEB_COUNT-th agreeing one: commit and rearm.
        if (deb_cnt[k] == DW'(DEB_COUNT - 1)) begin
          o1_nxt[k]      = deb_cand[k][1];
          o2_nxt[k]      = deb_cand[k][0];
          deb_cnt_nxt[k] = '0;
        end else begin
          deb_cnt_nxt[k] = deb_cnt[k] + DW'(1);
        end
      end else begin
        deb_cand_nxt[k] = {res_gt[k], res_lt[k]};
        deb_cnt_nxt[k]  = DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        deb_cnt[k]  <= '0;
        deb_cand[k] <= '0;
      end
    end else if (sweep_end) begin
      for (int k = 0; k < CHANNELS; k++) begin
        deb_cnt[k]  <= deb_cnt_nxt[k];
        deb_cand[k] <= deb_cand_nxt[k];
      end
    end
  end
`else
  always_comb begin
    o1_nxt = res_gt;
    o2_nxt = res_lt;
  end
`endif

  // All channels switch on the same edge as the transition into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_1 <= '0;
      output_2 <= '0;
    end else if (sweep_end) begin
      output_1 <= o1_nxt;
      output_2 <= o2_nxt;
    end
  end

endmodule

// File: tb/tb_comparator_bank.sv
module tb_comparator_bank;

  localparam int C   = 4;
  localparam int L   = 1;
  localparam int W   = 32;
  localparam int DEB = 3;

  logic             clk  = 1'b0;
  logic             rst  = 1'b1;
  logic             sta  = 1'b0;
  logic             sta2 = 1'b0;
  logic [C*W-1:0]   in1  = '0;
  logic [C*W-1:0]   in2  = '0;
  logic [W-1:0]     a2   = '0;
  logic [W-1:0]     b2   = '0;
  logic [C-1:0]     o1, o2;
  logic             busy, done;
  logic [0:0]       o1b, o2b;
  logic             busy2, done2;

  always #5 clk = ~clk;

  comparator_bank dut (
    .clk(clk), .rst(rst), .sta(sta), .input_1(in1), .input_2(in2),
    .output_1(o1), .output_2(o2), .busy(busy), .done_sig(done)
  );

  comparator_bank #(.CHANNELS(1), .CMP_LATENCY(3)) dut2 (
    .clk(clk), .rst(rst), .sta(sta2), .input_1(a2), .input_2(b2),
    .output_1(o1b), .output_2(o2b), .busy(busy2), .done_sig(done2)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Float ordering via a signed key: +x -> mag, -x -> -mag (so +0 == -0).
  function automatic logic [1:0] ref_cmp(input logic [31:0] a, input logic [31:0] b);
    longint ka, kb;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return 2'b00;
    ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    return {ka > kb, ka < kb};
  endfunction

  // Model: a sweep takes C+L+1 edges to done, then one DONE cycle.
  int           rem = 0;
  logic [C-1:0] m_o1 = '0, m_o2 = '0, pend1 = '0, pend2 = '0;
  int           dcnt  [C];
  logic [1:0]   dcand [C];
  logic         m_busy, m_done;
  assign m_busy = (rem != 0);
  assign m_done = (rem == 1);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= 0;
      m_o1 <= '0;
      m_o2 <= '0;
      for (int k = 0; k < C; k++) begin
        dcnt[k]  <= 0;
        dcand[k] <= 2'b00;
      end
    end else if (rem == 0) begin
      if (sta) begin
        rem <= C + L + 2;
        for (int k = 0; k < C; k++)
          {pend1[k], pend2[k]} <= ref_cmp(in1[k*W +: W], in2[k*W +: W]);
      end
    end else begin
      rem <= rem - 1;
      if (rem == 2) begin
`ifdef COMPARATOR_DEBOUNCE_EN
        for (int k = 0; k < C; k++) begin
          if ({pend1[k], pend2[k]} == {m_o1[k], m_o2[k]}) dcnt[k] <= 0;
          else if ({pend1[k], pend2[k]} == dcand[k]) begin
            if (dcnt[k] + 1 >= DEB) begin
              m_o1[k] <= dcand[k][1];
              m_o2[k] <= dcand[k][0];
              dcnt[k] <= 0;
            end else dcnt[k] <= dcnt[k] + 1;
          end else begin
            dcand[k] <= {pend1[k], pend2[k]};
            dcnt[k]  <= 1;
          end
        end
`else
        m_o1 <= pend1;
        m_o2 <= pend2;
`endif
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("out1", {28'd0, o1}, {28'd0, m_o1});
    chk("out2", {28'd0, o2}, {28'd0, m_o2});
  end

  task automatic sweep(input int which, input logic [C*W-1:0] a, input logic [C*W-1:0] b,
                       output int lat);
    @(posedge clk); #1;
    if (which == 0) begin in1 = a; in2 = b; sta = 1'b1; end
    else begin a2 = a[W-1:0]; b2 = b[W-1:0]; sta2 = 1'b1; end
    @(posedge clk); #1;
    sta = 1'b0; sta2 = 1'b0;
    lat = 0;
    while (((which == 0) ? done : done2) == 1'b0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  function automatic logic [C*W-1:0] pk(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  logic [C*W-1:0] def_a, def_b, neg_a, neg_b, lt_a, lt_b, gt_a, gt_b;
  int lat, dc;
  int pat [9];
  int e1  [9];
  int e2  [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    def_a = pk(32'h40000000, 32'hBF800000, 32'h00000000, 32'h7FC00000);
    def_b = pk(32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000);
    neg_a = pk(32'hC0000000, 32'h7F800000, 32'h00000002, 32'hFF800000);
    neg_b = pk(32'hBF800000, 32'h7F7FFFFF, 32'h00000001, 32'h7F800000);
    lt_a  = pk(32'h3F800000, 32'h0, 32'h0, 32'h0);
    lt_b  = pk(32'h40000000, 32'h0, 32'h0, 32'h0);
    gt_a  = lt_b;
    gt_b  = lt_a;

    // Pin the reference compare with hand-worked values.
    chk("ref_gt",   {30'd0, ref_cmp(32'h40000000, 32'h3F800000)}, 32'd2);
    chk("ref_neg",  {30'd0, ref_cmp(32'hC0000000, 32'hBF800000)}, 32'd1);
    chk("ref_inf",  {30'd0, ref_cmp(32'h7F800000, 32'h7F7FFFFF)}, 32'd2);
    chk("ref_zero", {30'd0, ref_cmp(32'h00000000, 32'h80000000)}, 32'd0);
    chk("ref_nan",  {30'd0, ref_cmp(32'h7FC00000, 32'h3F800000)}, 32'd0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out1", {28'd0, o1}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    sweep(0, def_a, def_b, lat);
    chk("lat_default", lat, 6);
`ifndef COMPARATOR_DEBOUNCE_EN
    chk("def_out1", {28'd0, o1}, 32'h1);
    chk("def_out2", {28'd0, o2}, 32'h2);
    chk("model_out1", {28'd0, m_o1}, 32'h1);
`endif

    // Reset two cycles into a sweep.
    @(posedge clk); #1 in1 = def_a; in2 = def_b; sta = 1'b1;
    @(posedge clk); #1 sta = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("midrst_out1", {28'd0, o1}, 32'd0);
    chk("midrst_out2", {28'd0, o2}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    dc = 0;
    repeat (10) begin @(posedge clk); #1; if (done) dc++; end
    chk("midrst_no_done", dc, 0);
    sweep(0, def_a, def_b, lat);
    chk("lat_after_rst", lat, 6);
`ifndef COMPARATOR_DEBOUNCE_EN
    chk("after_rst_out1", {28'd0, o1}, 32'h1);
    chk("after_rst_out2", {28'd0, o2}, 32'h2);
`endif

    // Capture stability plus a dropped sta while busy.
    @(posedge clk); #1 in1 = neg_a; in2 = neg_b; sta = 1'b1;
    @(posedge clk); #1 sta = 1'b0; in1 = def_a;
    @(posedge clk);
    @(posedge clk); #1 sta = 1'b1;
    @(posedge clk); #1 sta = 1'b0;
    dc = 0;
    repeat (15) begin @(posedge clk); #1; if (done) dc++; end
    chk("one_done", dc, 1);
`ifndef COMPARATOR_DEBOUNCE_EN
    chk("captured_out1", {28'd0, o1}, 32'h6);
    chk("captured_out2", {28'd0, o2}, 32'h9);
`endif

    // Channel 0 flip sequence L,L,L,G,G,L,G,G,G from reset.
    pat = '{0, 0, 0, 1, 1, 0, 1, 1, 1};
`ifdef COMPARATOR_DEBOUNCE_EN
    e1 = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    e2 = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
`else
    e1 = '{0, 0, 0, 1, 1, 0, 1, 1, 1};
    e2 = '{1, 1, 1, 0, 0, 1, 0, 0, 0};
`endif
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (pat[i] == 1) sweep(0, gt_a, gt_b, lat);
      else             sweep(0, lt_a, lt_b, lat);
      chk("flip_lat", lat, 6);
      chk("flip_out1_ch0", {31'd0, o1[0]}, e1[i]);
      chk("flip_out2_ch0", {31'd0, o2[0]}, e2[i]);
    end

    // Single channel, three-stage pipe, back-to-back sweeps.
    sweep(1, {96'd0, 32'h40000000}, {96'd0, 32'h3F800000}, lat);
    chk("c1_lat0", lat, 5);
`ifndef COMPARATOR_DEBOUNCE_EN
    chk("c1_out1_0", {31'd0, o1b}, 32'd1);
    chk("c1_out2_0", {31'd0, o2b}, 32'd0);
`endif
    sweep(1, {96'd0, 32'hBF800000}, {96'd0, 32'h3F800000}, lat);
    chk("c1_lat1", lat, 5);
`ifndef COMPARATOR_DEBOUNCE_EN
    chk("c1_out1_1", {31'd0, o1b}, 32'd0);
    chk("c1_out2_1", {31'd0, o2b}, 32'd1);
`endif
    sweep(1, {96'd0, 32'h3F800000}, {96'd0, 32'h3F800000}, lat);
    chk("c1_lat2", lat, 5);
    chk("c1_out1_2", {31'd0, o1b}, 32'd0);
    chk("c1_out2_2", {31'd0, o2b}, 32'd0);
    @(posedge clk); #1;
    chk("c1_idle", {31'd0, busy2}, 32'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/comparator_bank.md
Name: comparator_bank

Overview:
- Multi-channel successor to the single-pair float comparator in the PV control system.
- Compares CHANNELS pairs of IEEE-754 single-precision operands per sweep by time-multiplexing one native-RTL compare pipeline; no vendor IP, no DSP.
- Presents per-channel greater/less flags, updated atomically, with a start/done handshake.
- Feeds MPPT and protection logic that needs several threshold checks per solver step.

Parameters:
- WIDTH, 32 (`SINGLE), operand width; IEEE-754 single layout fixed, WIDTH must be 32.
- CHANNELS, 4, number of operand pairs per sweep; 1..16.
- CMP_LATENCY, 1, register stages in the compare pipeline; 1..3.
- DEB_COUNT, 3, consecutive sweeps required before an output changes; used only with the optional feature; 2..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sta  in  1  single-cycle start pulse; ignored while busy.
- input_1  in  CHANNELS*WIDTH  operand A; channel k occupies bits [k*WIDTH +: WIDTH].
- input_2  in  CHANNELS*WIDTH  operand B, same packing.
- output_1  out  CHANNELS  bit k = A_k > B_k.
- output_2  out  CHANNELS  bit k = A_k < B_k.
- busy  out  1  high from the cycle after an accepted sta until done_sig.
- done_sig  out  1  one-cycle pulse; outputs are valid from this cycle onward.

Behaviour:
- Reset: output_1 = 0, output_2 = 0, busy = 0, done_sig = 0, FSM = IDLE, pipeline valid bits cleared, debounce counters = 0. Reset is asynchronous and may assert at any point; it aborts a sweep in flight and takes effect immediately.
- Capture: on the edge where sta = 1 in IDLE (edge T0), latch input_1/input_2 into shadow registers. Later input changes do not affect the sweep.
- FSM states:
  - IDLE: accepted sta goes to ISSUE.
  - ISSUE: channel index 0..CHANNELS-1, one channel per cycle. Channel k enters the pipe at edge T(k+1). After the last channel, go to DRAIN.
  - DRAIN: wait for the pipe to empty, then go to DONE.
  - DONE: one cycle, then IDLE.
- Latency: the result for channel k is ready at edge T(k+1+CMP_LATENCY) and is written to a per-channel result register.
  - output_1/output_2 update all channels together at edge T(CHANNELS+CMP_LATENCY+1).
  - done_sig is high during the cycle following that edge.
  - Total is CHANNELS+CMP_LATENCY+1 cycles from sta to done (defaults: 6).
- busy = (FSM != IDLE). sta while busy is dropped: no queueing, no error.
- sta in the DONE cycle is ignored. A new sweep may start on the cycle after done_sig.
- Compare arithmetic (sign-magnitude):
  - Signs differ: the positive operand is greater.
  - Both positive: compare the 31-bit magnitudes unsigned.
  - Both negative: the larger magnitude is the lesser value.
  - +0 and -0 compare equal: both flags 0.
  - NaN (exp = 0xFF, mantissa != 0) on either side: both flags 0.
  - Infinities order normally.
  - Denormals compare by bit pattern, with no flush.
- Outputs hold their values between sweeps.

Optional Feature:
- Macro: COMPARATOR_DEBOUNCE_EN.
- Defined:
  - Each channel has a counter of width clog2(DEB_COUNT+1) and a 2-bit candidate code.
  - A sweep result equal to the current output clears the counter.
  - A result that differs from the current output and equals the candidate increments the counter.
  - A differing result that does not equal the candidate loads it as the new candidate with counter = 1.
  - When the counter reaches DEB_COUNT, the outputs take the candidate at the done edge and the counter clears.
  - done_sig timing is unchanged.
- Undefined: outputs take the raw result every sweep; counters are not instantiated.

Test Plan:
- Reset mid-sweep: pulse sta, assert rst at cycle 2 → all outputs 0 immediately, busy = 0, no done_sig; the next sta completes normally.
- Defaults: ch0 A = 2.0 (0x40000000), B = 1.0 (0x3F800000); ch1 A = -1.0 (0xBF800000), B = 1.0; ch2 A = +0, B = -0 (0x80000000); ch3 A = NaN (0x7FC00000), B = 1.0 → done_sig exactly 6 cycles after sta, output_1 = 4'b0001, output_2 = 4'b0010.
- Negative ordering: A = -2.0 (0xC0000000), B = -1.0 → agb = 0, alb = 1. Infinity: A = +inf (0x7F800000), B = 0x7F7FFFFF → agb = 1.
- Input stability: change input_1 on the cycle after sta → results reflect the captured values. A second sta while busy → exactly one done_sig.
- Debounce (macro defined, DEB_COUNT = 3): ch0 flips from 1.0 vs 2.0 to 2.0 vs 1.0.
  - output_1[0] rises only on the third consecutive done.
  - An interleaved reverting sweep resets the count.
- Parameter sweep: CHANNELS = 1, CMP_LATENCY = 3 → done 5 cycles after sta; back-to-back sweeps started on the cycle after each done.
